// File: rtl/dbus_uncached_axi_pkg.sv
// Shared types for the uncached data-bus bridge: physical address, write-buffer entry,
// AXI request/response bundles and the FSM state encodings.
package dbus_uncached_axi_pkg;

    typedef logic [31:0] phys_t;
    typedef logic [31:0] uint32_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef struct packed {
        phys_t      addr;
        uint32_t    data;
        logic [3:0] be;
    } uncached_wb_entry_t;

    typedef struct packed {
        phys_t      araddr;
        logic [7:0] arlen;
        logic [2:0] arsize;
        logic [1:0] arburst;
        logic       arlock;
        logic [3:0] arcache;
        logic [2:0] arprot;
        logic       arvalid;
        logic       rready;
        phys_t      awaddr;
        logic [7:0] awlen;
        logic [2:0] awsize;
        logic [1:0] awburst;
        logic       awlock;
        logic [3:0] awcache;
        logic [2:0] awprot;
        logic       awvalid;
        uint32_t    wdata;
        logic [3:0] wstrb;
        logic       wlast;
        logic       wvalid;
        logic       bready;
    } axi_req_t;

    typedef struct packed {
        logic       arready;
        uint32_t    rdata;
        logic [1:0] rresp;
        logic       rlast;
        logic       rvalid;
        logic       awready;
        logic       wready;
        logic [1:0] bresp;
        logic       bvalid;
    } axi_resp_t;

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_DONE} rstate_t;

endpackage

// File: rtl/dbus_uncached_axi_wbuf.sv
// Posted-write buffer: synchronous FIFO of uncached store entries with a head peek.
module uncached_wbuf
    import dbus_uncached_axi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  uncached_wb_entry_t din,
    output uncached_wb_entry_t head,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    uncached_wb_entry_t mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full/empty come from the registered count, so a push into a full buffer is
    // refused even when a pop happens in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dbus_uncached_axi.sv
// Uncached CPU data-bus bridge: stores are posted into a write buffer and drained as
// single-beat AXI writes; loads wait for the buffer to drain, then issue one AXI read.
module dbus_uncached_axi
    import dbus_uncached_axi_pkg::*;
#(
    parameter int         WB_DEPTH  = 4,
    parameter logic [3:0] AXI_CACHE = 4'b0000,
    parameter logic [2:0] AXI_PROT  = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uncached_read,
    input  logic        uncached_write,
    input  logic [31:0] address,
    input  logic [31:0] wrdata,
    input  logic [3:0]  byteenable,
    output logic        uncached_stall,
    output logic [31:0] uncached_rddata,
    output axi_req_t    axi_req,
    input  axi_resp_t   axi_resp
);
    uncached_wb_entry_t wb_in;
    uncached_wb_entry_t wb_head;
    logic               wb_push;
    logic               wb_pop;
    logic               wb_full;
    logic               wb_empty;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;
    logic    aw_done, w_done, aw_fire, w_fire;
    logic    awvalid, wvalid, bready;
    logic    arvalid, rready, rd_start, rd_capture;
    logic    rd_drop;
    phys_t   rd_addr;
    logic    unused_resp;

    // Error responses have no exception path in this core.
    assign unused_resp = ^{axi_resp.rresp, axi_resp.rlast, axi_resp.bresp};

    assign wb_in   = {address, wrdata, byteenable};
    assign wb_push = uncached_write & ~wb_full;

    assign uncached_stall = (uncached_write & wb_full) |
                            (uncached_read & (rstate != R_DONE));

    uncached_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wb_push),
        .pop   (wb_pop),
        .din   (wb_in),
        .head  (wb_head),
        .full  (wb_full),
        .empty (wb_empty)
    );

    // AW and W complete independently; the response phase opens only once both have.
    always_comb begin
        wstate_nxt = wstate;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        aw_fire    = 1'b0;
        w_fire     = 1'b0;
        wb_pop     = 1'b0;
        case (wstate)
            W_IDLE: if (!wb_empty) wstate_nxt = W_SEND;
            W_SEND: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                aw_fire = awvalid & axi_resp.awready;
                w_fire  = wvalid & axi_resp.wready;
                if ((aw_done | aw_fire) & (w_done | w_fire)) wstate_nxt = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (axi_resp.bvalid) begin
                    wb_pop     = 1'b1;
                    wstate_nxt = W_IDLE;
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // A read only starts with the buffer empty and the write engine idle, so every
    // earlier store has been acknowledged before the load reaches the bus.
    always_comb begin
        rstate_nxt = rstate;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rd_start   = 1'b0;
        rd_capture = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (uncached_read & ~uncached_write & wb_empty & (wstate == W_IDLE)) begin
                    rd_start   = 1'b1;
                    rstate_nxt = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (axi_resp.arready) rstate_nxt = R_R;
            end
            R_R: begin
                rready = 1'b1;
                if (axi_resp.rvalid) begin
                    if (uncached_read & ~rd_drop) begin
                        rd_capture = 1'b1;
                        rstate_nxt = R_DONE;
                    end else begin
                        rstate_nxt = R_IDLE;
                    end
                end
            end
            R_DONE:  rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate          <= W_IDLE;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            rstate          <= R_IDLE;
            rd_drop         <= 1'b0;
            uncached_rddata <= '0;
        end else begin
            wstate <= wstate_nxt;
            if (wstate == W_SEND) begin
                aw_done <= aw_done | aw_fire;
                w_done  <= w_done | w_fire;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            rstate <= rstate_nxt;
            // A flushed load still finishes on the bus, but its data is thrown away.
            if (rstate == R_IDLE)    rd_drop <= 1'b0;
            else if (!uncached_read) rd_drop <= 1'b1;
            if (rd_capture) uncached_rddata <= axi_resp.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_start) rd_addr <= address;
    end

    // Address/attribute fields are only driven alongside their valid, so the whole
    // bundle reads as zero whenever a channel is idle.
    always_comb begin
        axi_req         = '0;
        axi_req.arvalid = arvalid;
        axi_req.rready  = rready;
        axi_req.awvalid = awvalid;
        axi_req.wvalid  = wvalid;
        axi_req.bready  = bready;
        if (arvalid) begin
            axi_req.araddr  = rd_addr;
            axi_req.arsize  = AXI_SIZE_4B;
            axi_req.arburst = AXI_BURST_INCR;
            axi_req.arcache = AXI_CACHE;
            axi_req.arprot  = AXI_PROT;
        end
        if (awvalid) begin
            axi_req.awaddr  = wb_head.addr;
            axi_req.awsize  = AXI_SIZE_4B;
            axi_req.awburst = AXI_BURST_INCR;
            axi_req.awcache = AXI_CACHE;
            axi_req.awprot  = AXI_PROT;
        end
        if (wvalid) begin
            axi_req.wdata = wb_head.data;
            axi_req.wstrb = wb_head.be;
            axi_req.wlast = 1'b1;
        end
    end

endmodule

// File: tb/tb_dbus_uncached_axi.sv
// Bench for dbus_uncached_axi: randomized AXI slave plus a word-memory reference model,
// with directed scenarios for latency, ordering, buffer-full, ready skew, reset and flush.
`timescale 1ns/1ps
module tb_dbus_uncached_axi;
    import dbus_uncached_axi_pkg::*;

    localparam logic [3:0] TB_CACHE = 4'b0010;
    localparam logic [2:0] TB_PROT  = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uncached_read = 1'b0;
    logic        uncached_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wrdata = '0;
    logic [3:0]  byteenable = '0;
    logic        uncached_stall;
    logic [31:0] uncached_rddata;
    axi_req_t    req;
    axi_resp_t   resp;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // slave knobs and bookkeeping
    int ar_pct = 100, aw_pct = 100, w_pct = 100;
    int r_dly_max = 0, b_dly_max = 0, r_dly_fixed = -1;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
    int last_ar_cyc = -1, last_b_cyc = -1;
    logic [31:0] last_araddr = '0;
    logic r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    int r_wait = 0, b_wait = 0;
    logic [31:0] r_data = '0, cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic prev_ar_stall = 0, prev_aw_stall = 0, prev_w_stall = 0;
    logic [31:0] prev_araddr = '0, prev_awaddr = '0, prev_wdata = '0;
    logic [3:0]  prev_wstrb = '0;

    logic [31:0] smem [logic [31:0]];
    logic [31:0] refmem [logic [31:0]];
    uncached_wb_entry_t exp_wq [$];
    int st_acc = 0;

    dbus_uncached_axi #(.WB_DEPTH(4), .AXI_CACHE(TB_CACHE), .AXI_PROT(TB_PROT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .uncached_read   (uncached_read),
        .uncached_write  (uncached_write),
        .address         (address),
        .wrdata          (wrdata),
        .byteenable      (byteenable),
        .uncached_stall  (uncached_stall),
        .uncached_rddata (uncached_rddata),
        .axi_req         (req),
        .axi_resp        (resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : init_val(a);
    endfunction

    // AXI slave: samples handshakes on the falling edge, drives just after the rising edge
    initial begin : slave
        uncached_wb_entry_t e;
        resp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                prev_ar_stall = 0; prev_aw_stall = 0; prev_w_stall = 0;
            end else begin
                if (prev_ar_stall) begin
                    chk("ar_hold", req.arvalid, 1);
                    chk("araddr_hold", req.araddr, prev_araddr);
                end
                if (prev_aw_stall) begin
                    chk("aw_hold", req.awvalid, 1);
                    chk("awaddr_hold", req.awaddr, prev_awaddr);
                end
                if (prev_w_stall) begin
                    chk("w_hold", req.wvalid, 1);
                    chk("wdata_hold", req.wdata, prev_wdata);
                    chk("wstrb_hold", req.wstrb, prev_wstrb);
                end
                if (r_pend) chk("rready_hold", req.rready, 1);
                if (req.bready) chk("bready_early", aw_got & w_got, 1);
                if (aw_got) chk("aw_repeat", req.awvalid, 0);
                if (w_got) chk("w_repeat", req.wvalid, 0);

                if (req.bready && resp.bvalid) begin
                    b_cnt++;
                    last_b_cyc = cyc;
                    smem[cap_awaddr] = merge(smem_rd(cap_awaddr), cap_wdata, cap_wstrb);
                    if (exp_wq.size() == 0) begin
                        chk("write_unexpected", 1, 0);
                    end else begin
                        e = exp_wq.pop_front();
                        chk("wr_addr", cap_awaddr, e.addr);
                        chk("wr_data", cap_wdata, e.data);
                        chk("wr_strb", cap_wstrb, e.be);
                    end
                    aw_got = 0; w_got = 0; b_pend = 0;
                end
                if (req.rready && resp.rvalid) begin
                    r_cnt++;
                    r_pend = 0;
                end
                if (r_pend && r_wait > 0) r_wait--;
                if (b_pend && b_wait > 0) b_wait--;

                if (req.arvalid && resp.arready) begin
                    ar_cnt++;
                    last_ar_cyc = cyc;
                    last_araddr = req.araddr;
                    chk("arlen", req.arlen, 0);
                    chk("arsize", req.arsize, 3'b010);
                    chk("arburst", req.arburst, 2'b01);
                    chk("arcache_prot", {req.arlock, req.arcache, req.arprot}, {1'b0, TB_CACHE, TB_PROT});
                    r_pend = 1;
                    r_data = smem_rd(req.araddr);
                    r_wait = (r_dly_fixed >= 0) ? r_dly_fixed : int'($urandom_range(0, r_dly_max));
                end
                if (req.awvalid && resp.awready) begin
                    aw_cnt++;
                    aw_got = 1;
                    cap_awaddr = req.awaddr;
                    chk("awlen", req.awlen, 0);
                    chk("awsize", req.awsize, 3'b010);
                    chk("awburst", req.awburst, 2'b01);
                    chk("awcache_prot", {req.awlock, req.awcache, req.awprot}, {1'b0, TB_CACHE, TB_PROT});
                end
                if (req.wvalid && resp.wready) begin
                    w_cnt++;
                    w_got = 1;
                    cap_wdata = req.wdata;
                    cap_wstrb = req.wstrb;
                    chk("wlast", req.wlast, 1);
                end
                if (aw_got && w_got && !b_pend) begin
                    b_pend = 1;
                    b_wait = int'($urandom_range(0, b_dly_max));
                end
                prev_ar_stall = req.arvalid & ~resp.arready;
                prev_aw_stall = req.awvalid & ~resp.awready;
                prev_w_stall  = req.wvalid & ~resp.wready;
                prev_araddr = req.araddr;
                prev_awaddr = req.awaddr;
                prev_wdata  = req.wdata;
                prev_wstrb  = req.wstrb;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                resp = '0;
            end else begin
                resp.arready = (int'($urandom_range(0, 99)) < ar_pct);
                resp.awready = (int'($urandom_range(0, 99)) < aw_pct);
                resp.wready  = (int'($urandom_range(0, 99)) < w_pct);
                resp.rvalid  = r_pend && (r_wait == 0);
                resp.rdata   = resp.rvalid ? r_data : $urandom;
                resp.rresp   = 2'($urandom_range(0, 3));
                resp.rlast   = 1'b1;
                resp.bvalid  = b_pend && (b_wait == 0);
                resp.bresp   = 2'($urandom_range(0, 3));
            end
        end
    end

    // All CPU-side tasks start and end just after a rising edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int stalls);
        logic done = 0;
        uncached_wb_entry_t e;
        uncached_write = 1; address = a; wrdata = d; byteenable = be;
        stalls = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (!uncached_stall) begin
                done = 1;
                refmem[a] = merge(ref_rd(a), d, be);
                e.addr = a; e.data = d; e.be = be;
                exp_wq.push_back(e);
                st_acc++;
            end else begin
                stalls++;
            end
        end
        if (!done) chk("store_timeout", 0, 1);
        @(posedge clk);
        #1;
        uncached_write = 0;
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls);
        logic done = 0;
        uncached_read = 1; address = a;
        stalls = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (!uncached_stall) begin
                done = 1;
                chk("load_data", uncached_rddata, ref_rd(a));
            end else begin
                stalls++;
            end
        end
        if (!done) chk("load_timeout", 0, 1);
        @(posedge clk);
        #1;
        uncached_read = 0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 2000 && exp_wq.size() != 0; i++) @(posedge clk);
        chk(tag, exp_wq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int st, base_ar, base_aw, base_w, base_b, base_r, base_st;
        logic got;
        logic [31:0] old;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_stall_idle", uncached_stall, 0);
        chk("rst_rddata", uncached_rddata, 0);
        chk("rst_req_zero", req == '0, 1);
        uncached_read = 1;
        #1;
        chk("rst_stall_read", uncached_stall, 1);
        uncached_read = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // 1: single load, immediate readies
        smem[32'h1fd0_0010] = 32'hdead_beef;
        refmem[32'h1fd0_0010] = 32'hdead_beef;
        r_dly_fixed = 0;
        repeat (2) @(posedge clk);
        #1;
        do_load(32'h1fd0_0010, st);
        chk("t1_stall_cycles", st, 3);
        chk("t1_araddr", last_araddr, 32'h1fd0_0010);
        r_dly_fixed = -1;

        // 2: posted store then load of the same address
        b_dly_max = 3; r_dly_max = 2;
        do_store(32'h1faf_0000, 32'h1234_5678, 4'b0011, st);
        chk("t2_store_stall", st, 0);
        do_load(32'h1faf_0000, st);
        chk("t2_ar_after_b", last_ar_cyc > last_b_cyc, 1);
        wait_drain("t2_drain");

        // 3: buffer full with awready held low
        aw_pct = 0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h1faf_0100 + 32'(4 * i), $urandom, 4'hf, st);
            chk("t3_store_no_stall", st, 0);
        end
        base_b = b_cnt;
        fork
            begin
                repeat (6) @(posedge clk);
                #1;
                aw_pct = 100;
            end
        join_none
        do_store(32'h1faf_0110, 32'hcafe_f00d, 4'hf, st);
        chk("t3_fifth_stalled", st >= 6, 1);
        chk("t3_pop_before_accept", b_cnt > base_b, 1);
        wait_drain("t3_drain");

        // 4: ready skew in both directions
        base_aw = aw_cnt; base_w = w_cnt;
        aw_pct = 0; w_pct = 100;
        fork begin repeat (4) @(posedge clk); #1; aw_pct = 100; end join_none
        do_store(32'h1faf_0200, $urandom, 4'b0101, st);
        wait_drain("t4a_drain");
        aw_pct = 100; w_pct = 0;
        fork begin repeat (4) @(posedge clk); #1; w_pct = 100; end join_none
        do_store(32'h1faf_0204, $urandom, 4'b1010, st);
        wait_drain("t4b_drain");
        chk("t4_aw_count", aw_cnt - base_aw, 2);
        chk("t4_w_count", w_cnt - base_w, 2);

        // 5: reset while the read waits for data, and with stores buffered
        r_dly_fixed = 50;
        uncached_read = 1; address = 32'h1fd0_0040;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req.rready) got = 1;
        end
        chk("t5_reach_rr", got, 1);
        rst_n = 0; uncached_read = 0;
        #1;
        chk("t5_rready", req.rready, 0);
        chk("t5_arvalid", req.arvalid, 0);
        chk("t5_aw_w_valid", {req.awvalid, req.wvalid}, 0);
        chk("t5_rddata", uncached_rddata, 0);
        @(negedge clk);
        rst_n = 1; r_dly_fixed = -1;
        @(posedge clk);
        #1;
        aw_pct = 0;
        do_store(32'h1fee_0000, 32'h1111_2222, 4'hf, st);
        do_store(32'h1fee_0004, 32'h3333_4444, 4'hf, st);
        @(negedge clk);
        rst_n = 0;
        exp_wq.delete();
        @(negedge clk);
        rst_n = 1;
        aw_pct = 100;
        base_aw = aw_cnt;
        repeat (10) @(negedge clk);
        chk("t5_buffer_lost", aw_cnt - base_aw, 0);
        chk("t5_no_awvalid", req.awvalid, 0);
        @(posedge clk);
        #1;
        do_load(32'h1fd0_0010, st);

        // 6: load flushed while rvalid is delayed
        r_dly_fixed = 10;
        base_ar = ar_cnt; base_r = r_cnt;
        old = uncached_rddata;
        uncached_read = 1; address = 32'h1fd0_0020;
        repeat (4) @(posedge clk);
        #1;
        uncached_read = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (r_cnt > base_r) got = 1;
        end
        chk("t6_r_completed", got, 1);
        repeat (5) @(negedge clk);
        chk("t6_single_ar", ar_cnt - base_ar, 1);
        chk("t6_rddata_kept", uncached_rddata, old);
        chk("t6_idle", {req.arvalid, req.rready}, 0);
        r_dly_fixed = -1;
        @(posedge clk);
        #1;
        do_load(32'h1fd0_0020, st);

        // random mix against the reference memory
        base_aw = aw_cnt; base_w = w_cnt; base_st = st_acc;
        r_dly_max = 3; b_dly_max = 3;
        for (int n = 0; n < 250; n++) begin
            ar_pct = int'($urandom_range(30, 100));
            aw_pct = int'($urandom_range(30, 100));
            w_pct  = int'($urandom_range(30, 100));
            if ($urandom_range(0, 1) == 0)
                do_store(32'h1faf_1000 + 32'(4 * $urandom_range(0, 7)), $urandom,
                         4'($urandom_range(0, 15)), st);
            else
                do_load(32'h1faf_1000 + 32'(4 * $urandom_range(0, 7)), st);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_drain("rand_drain");
        chk("rand_aw_count", aw_cnt - base_aw, st_acc - base_st);
        chk("rand_w_count", w_cnt - base_w, st_acc - base_st);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
